step_pulse_gen: RTL
===================

Name: step_pulse_gen

Overview:
- Upstream stage of the stepper motor driver: converts a move command (step count, period, direction) into a timed train of single-cycle step pulses plus a direction level.
- The step output drives the driver's phase counter clock-enable; dir selects the phase sequence order.
- Tracks absolute signed position and reports completion with a one-cycle done pulse.
- Handshaked command interface, so a host FSM can queue moves back to back.

Parameters:
- CNT_W, 16, width of the step-count field.
- PER_W, 20, width of the period field (clk cycles per step).
- POS_W, 16, width of the signed position register.
- RAMP_OFFSET, 64, extra cycles added to the first step period (RAMP_EN only).
- RAMP_DEC, 4, period decrement applied after each step (RAMP_EN only).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command (high only in IDLE)
- cmd_count  in  CNT_W  number of steps to issue
- cmd_period  in  PER_W  cycles between steps; 0 is treated as 1
- cmd_dir  in  1  1 = forward (+1), 0 = reverse (-1)
- abort  in  1  synchronous stop request
- step  out  1  registered one-cycle step pulse
- dir  out  1  registered direction, stable for the whole move
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse at end of move
- aborted  out  1  valid with done; 1 = move ended by abort
- position  out  POS_W  signed absolute step position

Behaviour:
- Reset (async, reset_n = 0): all outputs and state are cleared to the following values.
  - state = IDLE, step = 0, dir = 0, busy = 0, done = 0, aborted = 0, position = 0.
  - cmd_ready = 1 once reset is released.
- State machine: IDLE, RUN. done and aborted are registered pulses issued on the RUN->IDLE edge.
- IDLE, with cmd_valid & cmd_ready at edge E0: latch count, effective period P = max(cmd_period, 1), and dir.
  - If count = 0: stay in IDLE; done = 1, aborted = 0 in the cycle after E0; no step is issued.
  - Otherwise: go to RUN, busy = 1 from the cycle after E0, and clear the period counter.
- RUN:
  - The period counter increments each cycle. When it reaches P-1, step = 1 for the following cycle, the counter reloads to 0, and remaining steps are decremented.
  - The first step pulse is high in cycle E0+P. Subsequent steps follow every P cycles.
- position updates on the same edge that raises step: +1 if dir = 1, -1 if dir = 0, wrapping modulo 2^POS_W.
- Last step (remaining reaches 0) at cycle T:
  - Cycle T+1: state = IDLE, busy = 0, done = 1, cmd_ready = 1.
  - A new command may be accepted at the end of T+1.
- abort:
  - Sampled high in RUN: go to IDLE at the next edge; done = 1, aborted = 1.
  - A step that would be issued on that same edge is suppressed (abort wins), and position is not updated for it.
  - abort is ignored in IDLE.
- cmd_valid while busy: ignored (cmd_ready = 0); the command is not latched.
- Reset asserted mid-move: immediate return to the reset values, including position = 0. The remainder of the move is discarded.
- dir changes only on command acceptance and never toggles during a move.

Optional Feature:
- Macro: STEP_RAMP_EN.
- Defined:
  - The first step period is P + RAMP_OFFSET.
  - After each step the current period is reduced by RAMP_DEC, saturating at P (never below P).
  - The ramp restarts on every accepted command.
  - Period arithmetic is done at PER_W+1 bits and saturates at 2^PER_W - 1.
- Undefined: every step uses period P exactly. RAMP_OFFSET and RAMP_DEC are unused.

Test Plan:
- Reset, then count = 3, period = 4, dir = 1 accepted at E0 → step high at E0+4, E0+8, E0+12; done at E0+13; position = 3; busy low at E0+13.
- count = 0, period = 10 → no step pulses; done = 1, aborted = 0 one cycle after acceptance; cmd_ready stays 1.
- From position 0: count = 2, dir = 0, period = 1 → steps in 2 consecutive cycles; position = 0xFFFE; dir output = 0 throughout.
- count = 5, period = 3, abort asserted on the cycle whose edge would issue step 3 → only 2 steps; done = 1, aborted = 1; position = 2.
- reset_n pulled low after step 2 of a 10-step move → outputs return to reset values immediately; no further steps after release; position = 0. A cmd_valid presented while busy is never acknowledged.
- STEP_RAMP_EN, RAMP_OFFSET = 8, RAMP_DEC = 4, period = 4, count = 4 → gaps of 12, 8, 4, 4 cycles between acceptance and successive steps.

Source files
------------

// File: rtl/step_pulse_gen_if.sv
// Command handshake bundle for step_pulse_gen: a host (master) offers a move
// (count, period, direction) and the pulse generator (slave) accepts it with ready.
interface step_pulse_gen_if #(
  parameter int CNT_W = 16,
  parameter int PER_W = 20
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_count;
  logic [PER_W-1:0] cmd_period;
  logic             cmd_dir;

  modport master (
    output cmd_valid, cmd_count, cmd_period, cmd_dir,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_count, cmd_period, cmd_dir,
    output cmd_ready
  );
endinterface

// File: rtl/step_pulse_gen.sv
// Stepper move generator: turns a (count, period, dir) command into timed single-cycle
// step pulses, tracks signed position. Optional acceleration ramp via macro STEP_RAMP_EN.
module step_pulse_gen #(
  parameter int CNT_W = 16,
  parameter int PER_W = 20,
  parameter int POS_W = 16
`ifdef STEP_RAMP_EN
  ,
  parameter int RAMP_OFFSET = 64,
  parameter int RAMP_DEC    = 4
`endif
) (
  input  logic                    clk,
  input  logic                    reset_n,
  step_pulse_gen_if.slave         cmd,
  input  logic                    abort,
  output logic                    step,
  output logic                    dir,
  output logic                    busy,
  output logic                    done,
  output logic                    aborted,
  output logic signed [POS_W-1:0] position
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [PER_W-1:0] PER_ONE  = {{(PER_W-1){1'b0}}, 1'b1};
  localparam logic [PER_W-1:0] PER_ZERO = {PER_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [POS_W-1:0] POS_ONE  = {{(POS_W-1){1'b0}}, 1'b1};
  localparam logic [POS_W-1:0] POS_ZERO = {POS_W{1'b0}};

`ifdef STEP_RAMP_EN
  localparam logic [PER_W:0] RAMP_OFFSET_W = (PER_W+1)'(RAMP_OFFSET);
  localparam logic [PER_W:0] RAMP_DEC_W    = (PER_W+1)'(RAMP_DEC);

  // First period of a move: base plus offset, clamped to the largest encodable period.
  function automatic logic [PER_W-1:0] ramp_first(input logic [PER_W-1:0] base);
    logic [PER_W:0] sum;
    sum = {1'b0, base} + RAMP_OFFSET_W;
    if (sum[PER_W]) begin
      ramp_first = {PER_W{1'b1}};
    end else begin
      ramp_first = sum[PER_W-1:0];
    end
  endfunction

  // Shrink the period after a step, never going below the commanded base period.
  function automatic logic [PER_W-1:0] ramp_next(input logic [PER_W-1:0] cur,
                                                 input logic [PER_W-1:0] base);
    logic [PER_W:0] diff;
    diff = {1'b0, cur} - RAMP_DEC_W;
    if (diff[PER_W] || (diff[PER_W-1:0] < base)) begin
      ramp_next = base;
    end else begin
      ramp_next = diff[PER_W-1:0];
    end
  endfunction

  logic [PER_W-1:0] base_r, base_s;
`endif

  state_t           state_r, state_s;
  logic [PER_W-1:0] cnt_r, cnt_s;
  logic [PER_W-1:0] per_r, per_s;
  logic [CNT_W-1:0] rem_r, rem_s;
  logic [POS_W-1:0] pos_r, pos_s;
  logic             dir_r, dir_s;
  logic             step_r, step_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             aborted_r, aborted_s;
  logic             ready_r, ready_s;
  logic [PER_W-1:0] eff_per_s;

  // Next-state and next-output decode for the IDLE/RUN move sequencer.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    per_s     = per_r;
    rem_s     = rem_r;
    pos_s     = pos_r;
    dir_s     = dir_r;
    step_s    = 1'b0;
    done_s    = 1'b0;
    aborted_s = 1'b0;
`ifdef STEP_RAMP_EN
    base_s    = base_r;
`endif
    if (cmd.cmd_period == PER_ZERO) begin
      eff_per_s = PER_ONE;
    end else begin
      eff_per_s = cmd.cmd_period;
    end

    case (state_r)
      ST_IDLE: begin
        if (cmd.cmd_valid) begin
          dir_s = cmd.cmd_dir;
          rem_s = cmd.cmd_count;
          cnt_s = PER_ZERO;
`ifdef STEP_RAMP_EN
          base_s = eff_per_s;
          per_s  = ramp_first(eff_per_s);
`else
          per_s  = eff_per_s;
`endif
          if (cmd.cmd_count == CNT_ZERO) begin
            done_s = 1'b1;
          end else begin
            state_s = ST_RUN;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        // Abort takes priority, so a step due on this edge is dropped with its position update.
        if (abort) begin
          state_s   = ST_IDLE;
          done_s    = 1'b1;
          aborted_s = 1'b1;
        end else if (rem_r == CNT_ZERO) begin
          state_s = ST_IDLE;
          done_s  = 1'b1;
        end else if (cnt_r == (per_r - PER_ONE)) begin
          step_s = 1'b1;
          cnt_s  = PER_ZERO;
          rem_s  = rem_r - CNT_ONE;
          if (dir_r) begin
            pos_s = pos_r + POS_ONE;
          end else begin
            pos_s = pos_r - POS_ONE;
          end
`ifdef STEP_RAMP_EN
          per_s = ramp_next(per_r, base_r);
`else
          per_s = per_r;
`endif
        end else begin
          cnt_s = cnt_r + PER_ONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    ready_s = (state_s == ST_IDLE);
    busy_s  = (state_s == ST_RUN);
  end

  // State and output registers; reset clears the move, including position.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= PER_ZERO;
      per_r     <= PER_ONE;
      rem_r     <= CNT_ZERO;
      pos_r     <= POS_ZERO;
      dir_r     <= 1'b0;
      step_r    <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      aborted_r <= 1'b0;
      ready_r   <= 1'b1;
`ifdef STEP_RAMP_EN
      base_r    <= PER_ONE;
`endif
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      per_r     <= per_s;
      rem_r     <= rem_s;
      pos_r     <= pos_s;
      dir_r     <= dir_s;
      step_r    <= step_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      aborted_r <= aborted_s;
      ready_r   <= ready_s;
`ifdef STEP_RAMP_EN
      base_r    <= base_s;
`endif
    end
  end

  assign cmd.cmd_ready = ready_r;
  assign step          = step_r;
  assign dir           = dir_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign aborted       = aborted_r;
  assign position      = pos_r;

endmodule
